sad_accumulator: RTL

Streaming sum-of-absolute-differences engine for the SAD block-matching datapath. It is the parametrised successor to the plain 8-bit subtractor: it takes LANES pixel pairs per beat, forms true absolute differences (no wrap-around), and accumulates them over a block of BLOCK_N pixels. It emits one SAD result per block over a valid/ready handshake. It sits between the pixel fetch logic and the best-match comparator.

---
 rtl/sad_accumulator.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sad_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : sad_accumulator
// Description : Streaming sum-of-absolute-differences engine. Takes LANES
//               pixel pairs per beat, forms true absolute differences and
//               accumulates them over a block of BLOCK_N pixels. Emits one
//               SAD per block over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module sad_accumulator #(
    parameter int DATA_W  = 8,
    parameter int LANES   = 4,
    parameter int BLOCK_N = 16,
    parameter int SAD_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] a_data,
    input  logic [LANES*DATA_W-1:0] b_data,
    output logic                    sad_valid,
    input  logic                    sad_ready,
    output logic [SAD_W-1:0]        sad
);

    localparam int BEATS = BLOCK_N / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Beat position within the current block
    logic [CNT_W-1:0]        beat_cnt;

    // Stage S1: registered per-lane absolute differences plus block markers
    logic                    s1_valid;
    logic                    s1_last;
    logic                    s1_first;
    logic [LANES*DATA_W-1:0] s1_diff;

    // Stage S2: running partial sum of the block in progress
    logic [SAD_W-1:0]        acc;

    logic [LANES*DATA_W-1:0] diff_comb;
    logic [SAD_W-1:0]        lane_sum;
    logic [SAD_W-1:0]        acc_base;
    logic [SAD_W-1:0]        acc_next;
    logic                    stall;
    logic                    accept;
    logic                    out_free;
    logic                    load;

    // Per-lane absolute difference; comparing first avoids any wrap-around
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [DATA_W-1:0] a_i;
            logic [DATA_W-1:0] b_i;
            assign a_i = a_data[i*DATA_W +: DATA_W];
            assign b_i = b_data[i*DATA_W +: DATA_W];
            assign diff_comb[i*DATA_W +: DATA_W] = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
        end
    endgenerate

    // Sum the registered lane differences at full result width
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + SAD_W'(s1_diff[i*DATA_W +: DATA_W]);
        end
    end

    // The first beat of a block restarts the sum instead of adding to stale acc
    assign acc_base = s1_first ? '0 : acc;
    assign acc_next = acc_base + lane_sum;

    // A completed block waiting on a full output register blocks the pipeline;
    // in_ready depends only on state and sad_ready, never on in_valid
    assign stall    = s1_valid && s1_last && sad_valid && !sad_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready && !clear;
    assign out_free = !sad_valid || sad_ready;
    assign load     = s1_valid && s1_last && out_free && !clear;

    // S1 capture and beat counting; clear wins over stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_first <= 1'b0;
            s1_diff  <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
            s1_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_diff  <= diff_comb;
                s1_last  <= (beat_cnt == LAST_BEAT);
                s1_first <= (beat_cnt == '0);
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    // S2 accumulation of each S1 beat, frozen while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (s1_valid && !stall) begin
            acc <= acc_next;
        end
    end

    // Output register: load a finished block, or retire a transferred result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sad_valid <= 1'b0;
            sad       <= '0;
        end else if (load) begin
            sad_valid <= 1'b1;
            sad       <= acc_next;
        end else if (sad_ready) begin
            sad_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
